// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage types and constants for the IF stage and its skid buffer.
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      SQUASH = 2'd2,
      TRAP   = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry word+PC buffer that catches a fetch completing while decode is stalled.
module fetch_skid_buffer
   import instruction_fetch_unit_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic        drain_i,
   input  logic        flush_i,
   input  logic [31:0] word_i,
   input  logic [31:0] pc_i,
   output logic [31:0] word_o,
   output logic [31:0] pc_o,
   output logic        valid_o
);

   logic [31:0] word_q, word_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;

   always_comb begin
      word_d  = word_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (flush_i || drain_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         word_d  = word_i;
         pc_d    = pc_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_q  <= NOP_INSTR;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign word_o  = word_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Pipeline IF stage: PC, BUSYWAIT fetch handshake, IF/ID register, stall/flush handling.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        CLK,
   input  logic        RESET_N,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_READ,
   input  logic [31:0] IMEM_READDATA,
   input  logic        IMEM_BUSYWAIT,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   output logic [31:0] IF_INSTR,
   output logic [31:0] IF_PC,
   output logic [31:0] IF_PC_PLUS4,
   output logic        IF_VALID,
   output logic        MISALIGNED
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  redirect_q, redirect_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  ifpc_q, ifpc_d;
   logic [31:0]  ifpc4_q, ifpc4_d;
   logic         valid_q, valid_d;

   logic         skid_load, skid_drain, skid_flush, skid_valid;
   logic [31:0]  skid_word, skid_pc;
   logic [31:0]  target;
   logic         target_bad;

`ifdef IF_MISALIGN_TRAP_EN
   assign target     = BRANCH_TARGET;
   assign target_bad = |BRANCH_TARGET[1:0];
`else
   assign target     = BRANCH_TARGET & 32'hFFFF_FFFC;
   assign target_bad = 1'b0;
`endif

   fetch_skid_buffer u_skid (
      .clk_i   (CLK),
      .rst_ni  (RESET_N),
      .load_i  (skid_load),
      .drain_i (skid_drain),
      .flush_i (skid_flush),
      .word_i  (IMEM_READDATA),
      .pc_i    (pc_q),
      .word_o  (skid_word),
      .pc_o    (skid_pc),
      .valid_o (skid_valid)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      redirect_d = redirect_q;
      instr_d    = instr_q;
      ifpc_d     = ifpc_q;
      ifpc4_d    = ifpc4_q;
      valid_d    = valid_q;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_flush = 1'b0;
      case (state_q)
         FETCH: begin
            if (BRANCH_TAKEN) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               if (target_bad) begin
                  state_d = TRAP;
               end else if (IMEM_BUSYWAIT) begin
                  redirect_d = target;
                  state_d    = SQUASH;
               end else begin
                  pc_d = target;
               end
            end else if (!IMEM_BUSYWAIT) begin
               if (STALL) begin
                  skid_load = 1'b1;
                  pc_d      = pc_plus4(pc_q);
                  state_d   = HOLD;
               end else begin
                  instr_d = IMEM_READDATA;
                  ifpc_d  = pc_q;
                  ifpc4_d = pc_plus4(pc_q);
                  valid_d = 1'b1;
                  pc_d    = pc_plus4(pc_q);
               end
            end else if (!STALL) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
            end
         end
         HOLD: begin
            if (BRANCH_TAKEN) begin
               skid_flush = 1'b1;
               valid_d    = 1'b0;
               instr_d    = NOP_INSTR;
               if (target_bad) begin
                  state_d = TRAP;
               end else begin
                  pc_d    = target;
                  state_d = FETCH;
               end
            end else if (!STALL) begin
               skid_drain = 1'b1;
               instr_d    = skid_word;
               ifpc_d     = skid_pc;
               ifpc4_d    = pc_plus4(skid_pc);
               valid_d    = skid_valid;
               state_d    = FETCH;
            end
         end
         SQUASH: begin
            // Keep the in-flight read alive at the old PC; its data is thrown away.
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (BRANCH_TAKEN && target_bad) begin
               state_d = TRAP;
            end else begin
               if (BRANCH_TAKEN) redirect_d = target;
               if (!IMEM_BUSYWAIT) begin
                  pc_d    = BRANCH_TAKEN ? target : redirect_q;
                  state_d = FETCH;
               end
            end
         end
`ifdef IF_MISALIGN_TRAP_EN
         TRAP: begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
         end
`endif
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         redirect_q <= RESET_PC;
         instr_q    <= NOP_INSTR;
         ifpc_q     <= '0;
         ifpc4_q    <= 32'd4;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
         instr_q    <= instr_d;
         ifpc_q     <= ifpc_d;
         ifpc4_q    <= ifpc4_d;
         valid_q    <= valid_d;
      end
   end

   assign IMEM_ADDR   = pc_q;
   assign IMEM_READ   = (state_q == FETCH) || (state_q == SQUASH);
   assign IF_INSTR    = instr_q;
   assign IF_PC       = ifpc_q;
   assign IF_PC_PLUS4 = ifpc4_q;
   assign IF_VALID    = valid_q;

`ifdef IF_MISALIGN_TRAP_EN
   assign MISALIGNED = (state_q == TRAP);
`else
   assign MISALIGNED = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected fetches are queued per scenario.
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b1;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_READ;
   logic [31:0] IMEM_READDATA;
   logic        IMEM_BUSYWAIT = 1'b0;
   logic        STALL = 1'b0;
   logic        BRANCH_TAKEN = 1'b0;
   logic [31:0] BRANCH_TARGET = '0;
   logic [31:0] IF_INSTR;
   logic [31:0] IF_PC;
   logic [31:0] IF_PC_PLUS4;
   logic        IF_VALID;
   logic        MISALIGNED;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   always #5 CLK = ~CLK;

   // ADDI x1,x0,<addr[11:0]>: each word encodes where it came from.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return {a[11:0], 5'd0, 3'b000, 5'd1, 7'h13};
   endfunction

   assign IMEM_READDATA = imem_word(IMEM_ADDR);

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .IMEM_ADDR     (IMEM_ADDR),
      .IMEM_READ     (IMEM_READ),
      .IMEM_READDATA (IMEM_READDATA),
      .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
      .STALL         (STALL),
      .BRANCH_TAKEN  (BRANCH_TAKEN),
      .BRANCH_TARGET (BRANCH_TARGET),
      .IF_INSTR      (IF_INSTR),
      .IF_PC         (IF_PC),
      .IF_PC_PLUS4   (IF_PC_PLUS4),
      .IF_VALID      (IF_VALID),
      .MISALIGNED    (MISALIGNED)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic expect_fetch(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = imem_word(pc);
      sb.push_back(e);
   endtask

   // A new instruction reaches IF/ID whenever IF_VALID is set after an edge without STALL.
   task automatic tick();
      exp_t e;
      @(posedge CLK);
      #1;
      if (RESET_N && IF_VALID && !STALL) begin
         if (sb.size() == 0) begin
            check("unexpected_out", IF_PC, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("if_pc", IF_PC, e.pc);
            check("if_instr", IF_INSTR, e.instr);
            check("if_pc_plus4", IF_PC_PLUS4, e.pc + 32'd4);
         end
      end
   endtask

   task automatic check_reset_state();
      check("rst_addr", IMEM_ADDR, 32'h0);
      check("rst_read", 32'(IMEM_READ), 32'd1);
      check("rst_instr", IF_INSTR, NOP_INSTR);
      check("rst_if_pc", IF_PC, 32'h0);
      check("rst_pc_plus4", IF_PC_PLUS4, 32'h4);
      check("rst_valid", 32'(IF_VALID), 32'd0);
      check("rst_misaligned", 32'(MISALIGNED), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 RESET_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_reset_state();
      RESET_N = 1'b1;

      // zero-wait stream
      for (int i = 0; i < 4; i++) expect_fetch(32'(i * 4));
      repeat (4) tick();

      // three wait cycles at 0x10
      IMEM_BUSYWAIT = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bubble_valid", 32'(IF_VALID), 32'd0);
         check("bubble_instr", IF_INSTR, NOP_INSTR);
         check("busy_addr", IMEM_ADDR, 32'h10);
         check("busy_read", 32'(IMEM_READ), 32'd1);
      end
      IMEM_BUSYWAIT = 1'b0;
      for (int i = 0; i < 4; i++) expect_fetch(32'h10 + 32'(i * 4));
      repeat (4) tick();

      // stall while word@0x20 completes
      STALL = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("stall_pc", IF_PC, 32'h1C);
         check("stall_valid", 32'(IF_VALID), 32'd1);
         check("hold_read", 32'(IMEM_READ), 32'd0);
      end
      STALL = 1'b0;
      expect_fetch(32'h20);
      tick();
      for (int i = 0; i < 7; i++) expect_fetch(32'h24 + 32'(i * 4));
      repeat (7) tick();

      // redirect during a wait at 0x40
      IMEM_BUSYWAIT = 1'b1;
      tick();
      check("pre_squash_addr", IMEM_ADDR, 32'h40);
      BRANCH_TAKEN = 1'b1;
      BRANCH_TARGET = 32'h100;
      tick();
      BRANCH_TAKEN = 1'b0;
      check("squash_addr", IMEM_ADDR, 32'h40);
      check("squash_read", 32'(IMEM_READ), 32'd1);
      check("squash_valid", 32'(IF_VALID), 32'd0);
      tick();
      check("squash_addr2", IMEM_ADDR, 32'h40);
      check("squash_valid2", 32'(IF_VALID), 32'd0);
      IMEM_BUSYWAIT = 1'b0;
      tick();
      check("redirect_addr", IMEM_ADDR, 32'h100);
      check("redirect_valid", 32'(IF_VALID), 32'd0);
      expect_fetch(32'h100);
      tick();

      // branch and stall together
      STALL = 1'b1;
      BRANCH_TAKEN = 1'b1;
      BRANCH_TARGET = 32'h200;
      tick();
      STALL = 1'b0;
      BRANCH_TAKEN = 1'b0;
      check("flush_stall_valid", 32'(IF_VALID), 32'd0);
      check("flush_stall_addr", IMEM_ADDR, 32'h200);
      expect_fetch(32'h200);
      expect_fetch(32'h204);
      repeat (2) tick();

      // PC wraps past the top of the address space
      BRANCH_TAKEN = 1'b1;
      BRANCH_TARGET = 32'hFFFF_FFFC;
      tick();
      BRANCH_TAKEN = 1'b0;
      check("wrap_addr", IMEM_ADDR, 32'hFFFF_FFFC);
      expect_fetch(32'hFFFF_FFFC);
      expect_fetch(32'h0);
      repeat (2) tick();

      // redirect while holding a skid entry drops it
      STALL = 1'b1;
      tick();
      check("hold_read2", 32'(IMEM_READ), 32'd0);
      BRANCH_TAKEN = 1'b1;
      BRANCH_TARGET = 32'h300;
      tick();
      STALL = 1'b0;
      BRANCH_TAKEN = 1'b0;
      check("hold_flush_valid", 32'(IF_VALID), 32'd0);
      check("hold_flush_addr", IMEM_ADDR, 32'h300);
      check("hold_flush_read", 32'(IMEM_READ), 32'd1);
      expect_fetch(32'h300);
      tick();

      // misaligned redirect
      BRANCH_TAKEN = 1'b1;
      BRANCH_TARGET = 32'h402;
      tick();
      BRANCH_TAKEN = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         check("trap_misaligned", 32'(MISALIGNED), 32'd1);
         check("trap_read", 32'(IMEM_READ), 32'd0);
         check("trap_valid", 32'(IF_VALID), 32'd0);
         tick();
      end
`else
      check("align_addr", IMEM_ADDR, 32'h400);
      check("align_misaligned", 32'(MISALIGNED), 32'd0);
      expect_fetch(32'h400);
      tick();
`endif

      // asynchronous reset in the middle of a wait
      IMEM_BUSYWAIT = 1'b1;
      tick();
      #2 RESET_N = 1'b0;
      #1;
      check_reset_state();
      @(posedge CLK);
      #1;
      IMEM_BUSYWAIT = 1'b0;
      RESET_N = 1'b1;
      expect_fetch(32'h0);
      expect_fetch(32'h4);
      repeat (2) tick();

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
